// File: rtl/reg_bank_param.sv
// reg_bank_param
// Parametrised integer register file for the pipelined core.
//   - NRD combinational read ports, register 0 reads as zero
//   - one write port, optional same-cycle write-to-read bypass
//   - per-register pending scoreboard (set on issue, cleared on writeback)
//   - software clear that sweeps registers 1..NREGS-1, one per cycle
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   we/wa/wd   write enable, address, data
//   ra         NRD packed read addresses, port i at [i*AW +: AW]
//   rd         NRD packed read data, port i at [i*XLEN +: XLEN]
//   iss_valid  mark iss_rd pending
//   iss_rd     destination register of the issued instruction
//   pend       pending bit per register (bit 0 always 0)
//   clr_req    single-cycle clear request
//   clr_busy   high while the sweep runs
//
// state  | meaning
// IDLE   | normal operation, writes and issues accepted
// SWEEP  | clearing register r_cnt this cycle, writes/issues dropped
module reg_bank_param #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 0,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic [NREGS-1:0]    pend,
    input  logic                clr_req,
    output logic                clr_busy
);

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_cnt;
    logic [AW-1:0]    w_cnt_nxt;
    logic             w_sweep_clr;
    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_nxt;
    logic             w_wr_ok;
    logic             w_iss_ok;

    // Register 0 and addresses beyond NREGS (non power-of-two depth) are not storage.
    function automatic logic f_valid_addr(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < 32'(NREGS));
    endfunction

    assign clr_busy = (r_state == S_SWEEP);
    assign w_wr_ok  = we && f_valid_addr(wa) && !clr_busy;
    assign w_iss_ok = iss_valid && f_valid_addr(iss_rd) && !clr_busy;
    assign pend     = r_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sweep_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = S_SWEEP;
                    w_cnt_nxt   = AW'(1);
                end
            end
            S_SWEEP: begin
                w_sweep_clr = 1'b1;
                w_cnt_nxt   = r_cnt + 1'b1;
                if (r_cnt == AW'(NREGS - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Clear is applied before set so a same-cycle issue to the written register wins.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_sweep_clr) w_pend_nxt[r_cnt] = 1'b0;
        if (w_wr_ok)     w_pend_nxt[wa]    = 1'b0;
        if (w_iss_ok)    w_pend_nxt[iss_rd] = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // Writes are blocked while sweeping, so the two updates never target the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wr_ok)     r_regs[wa]    <= wd;
            if (w_sweep_clr) r_regs[r_cnt] <= '0;
        end
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < NRD; i++) begin
            if (f_valid_addr(ra[i*AW +: AW])) begin
                if ((BYPASS != 0) && w_wr_ok && (ra[i*AW +: AW] == wa)) begin
                    rd[i*XLEN +: XLEN] = wd;
                end else begin
                    rd[i*XLEN +: XLEN] = r_regs[ra[i*AW +: AW]];
                end
            end
        end
    end

endmodule

// File: doc/reg_bank_param.md
Name: reg_bank_param

Overview:
Parametrised multi-port integer register file for the pipelined core, the successor to the fixed 32x32 two-read-port Reg_Bank. Width, depth and read-port count are generalised. Adds an optional write-to-read bypass, a per-register pending scoreboard for hazard detection, and a sequenced software clear (sweep) FSM. It sits between decode (read and issue) and writeback (write).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of registers; legal range 2..64; register 0 is hardwired to zero
NRD, 2, number of read ports; legal range 1..4
BYPASS, 0, 1 = a write in the current cycle is forwarded to matching read ports combinationally; 0 = reads return the old value until after the write edge
AW, $clog2(NREGS), address width; derived localparam, not overridable

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
we  in  1  write enable
wa  in  AW  write address
wd  in  XLEN  write data
ra  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
rd  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
iss_valid  in  1  mark destination register pending (instruction issued)
iss_rd  in  AW  destination register to mark pending
pend  out  NREGS  pending bit per register; bit 0 is constant 0
clr_req  in  1  single-cycle pulse requesting a clear of all registers
clr_busy  out  1  high while the sweep is in progress

Behaviour:
- Reset (async assert, released synchronously by the environment):
  - all registers 0, pend = 0, clr_busy = 0, FSM = IDLE, sweep counter = 0.
  - rd reflects the cleared contents immediately (all 0).
- Reads are combinational with zero latency.
  - ra_i == 0 or ra_i >= NREGS: rd_i = 0.
  - otherwise rd_i = reg[ra_i].
- Write acceptance: wr_ok = we && wa != 0 && wa < NREGS && !clr_busy.
  - When wr_ok, reg[wa] <= wd on the rising edge.
  - Writes to register 0, to out-of-range addresses, or during the sweep are silently dropped.
- Bypass:
  - BYPASS=1: when wr_ok && ra_i == wa, rd_i = wd in the same cycle.
  - BYPASS=0: rd_i shows the old value until after the edge.
- Scoreboard, evaluated per rising edge:
  - iss_valid && iss_rd != 0 && iss_rd < NREGS && !clr_busy: set pend[iss_rd].
  - wr_ok: clear pend[wa].
  - Same register set and cleared in the same cycle: set wins (a new producer was issued).
  - pend is a registered output.
- Sweep FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on clr_req. Counter loads 1; clr_busy goes 1 from the next cycle.
  - In SWEEP, each edge does reg[cnt] <= 0, pend[cnt] <= 0, cnt <= cnt + 1.
  - When cnt == NREGS-1 is cleared, next state is IDLE and clr_busy drops the following cycle.
  - Duration is exactly NREGS-1 cycles with clr_busy high.
  - clr_req while in SWEEP is ignored (no restart).
  - we and iss_valid in the same cycle as an accepted clr_req are still honoured; that cycle is not yet busy.
  - Reads during the sweep return current contents, so already-swept registers read 0.
- Reset mid-sweep: aborts immediately to the reset state.
- No X on any output after reset, for any input combination.

Test Plan:
- Reset, XLEN=32, NREGS=32, NRD=3: write 0xDEADBEEF to r3 and 0x12345678 to r5, then read ra={3,5,4} -> rd={0xDEADBEEF, 0x12345678, 0x0}.
- Write 0xFFFFFFFF to r0, then read r0 -> 0x0; pend[0] stays 0 after iss_valid with iss_rd=0.
- Read-during-write of 0x5555AAAA to r3 (previously 0), ra0=3, sampled 1 ns before the edge: BYPASS=0 -> 0x0, then 0x5555AAAA after the edge; BYPASS=1 -> 0x5555AAAA before the edge.
- iss_valid with iss_rd=7 -> pend[7]=1 after the edge. Write r7 -> pend[7]=0. Same-cycle iss_rd=7 and write to r7 -> pend[7] stays 1.
- Fill r1..r31 with nonzero values, then pulse clr_req:
  - clr_busy high for exactly 31 cycles.
  - A write to r9 mid-sweep is dropped.
  - Afterwards every register reads 0 and pend = 0.
- Start a sweep, assert rst after 10 cycles -> clr_busy = 0, all registers 0 immediately. A subsequent write to r2 of 0xA5A5A5A5 reads back correctly.
